// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
//   Instruction fetch stage. Owns the PC, issues word fetches to instruction
//   memory (valid/ready request, in-order responses) and buffers returned
//   instructions in a small FIFO presented to decode with a valid/ready handshake.
//   A redirect flushes the FIFO, reloads the PC and drops every response still
//   in flight for the old stream.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   Defined:   a redirect to a non-word-aligned PC enters a sticky fault state
//              (fetch_fault=1, no fetching) until an aligned redirect or reset.
//   Undefined: fetch_fault is tied 0 and redirect_pc[1:0] is forced to 00.
//
// Ports:
//   clock, reset_n                      clock (rising edge), async active-low reset
//   imem_req_valid/ready/addr           fetch request channel
//   imem_resp_valid/data                in-order fetch responses
//   inst_valid/ready, inst, inst_pc     FIFO head towards decode
//   redirect_valid, redirect_pc         PC redirect from the execute side
//   fetch_fault                         misaligned-redirect flag
module fetch_prefetch_unit #(
    parameter logic [31:0] INITIAL_PC      = 32'h0040_0000,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);
    localparam int unsigned   PW        = $clog2(FIFO_DEPTH);
    localparam int unsigned   CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {StFetch, StFlush, StFault} state_e;

    state_e        state_q;
    logic          active_q;  // keeps imem_req_valid low while reset is asserted
    logic [31:0]   fetch_pc_q;
    logic [31:0]   resp_pc_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] drop_cnt_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [31:0]   buf_inst_q [FIFO_DEPTH];
    logic [31:0]   buf_pc_q   [FIFO_DEPTH];

    logic [CW:0]   credits_used;
    logic [CW-1:0] outstanding_nx;
    logic [CW-1:0] count_nx;
    logic          accept;
    logic          push;
    logic          pop;
    logic          misaligned;
    logic [31:0]   redirect_target;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q;
    assign misaligned      = (redirect_pc[1:0] != 2'b00);
    assign redirect_target = redirect_pc;
    assign fetch_fault     = fault_q;
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign misaligned           = 1'b0;
    assign redirect_target      = {redirect_pc[31:2], 2'b00};
    assign fetch_fault          = 1'b0;
`endif

    // Every issued request reserves a FIFO slot, so the FIFO can never overflow.
    assign credits_used   = {1'b0, outstanding_q} + {1'b0, count_q};
    assign imem_req_valid = active_q && (state_q == StFetch)
                            && (credits_used < {1'b0, DEPTH_C})
                            && (outstanding_q < MAX_OUT_C);
    assign imem_req_addr  = fetch_pc_q;

    assign inst_valid = (count_q != '0);
    assign inst       = buf_inst_q[rd_ptr_q];
    assign inst_pc    = buf_pc_q[rd_ptr_q];

    assign accept = imem_req_valid && imem_req_ready;
    assign pop    = inst_valid && inst_ready;
    // Responses in a redirect cycle belong to the old stream and are never kept.
    assign push   = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid
                    && (state_q != StFault);

    assign outstanding_nx = outstanding_q + CW'(accept) - CW'(imem_resp_valid);
    assign count_nx       = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StFetch;
            active_q      <= 1'b0;
            fetch_pc_q    <= INITIAL_PC;
            resp_pc_q     <= INITIAL_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                buf_inst_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            active_q      <= 1'b1;
            outstanding_q <= outstanding_nx;
            if (redirect_valid) begin
                // Everything still in flight after this cycle is stale.
                count_q    <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
                fetch_pc_q <= redirect_target;
                resp_pc_q  <= redirect_target;
                drop_cnt_q <= outstanding_nx;
                if (misaligned) begin
                    state_q <= StFault;
                end else if (outstanding_nx != '0) begin
                    state_q <= StFlush;
                end else begin
                    state_q <= StFetch;
                end
`ifdef FETCH_MISALIGN_CHECK_EN
                fault_q <= misaligned;
`endif
            end else begin
                if (accept) begin
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                end
                if (imem_resp_valid && (drop_cnt_q != '0)) begin
                    drop_cnt_q <= drop_cnt_q - CW'(1);
                    if ((state_q == StFlush) && (drop_cnt_q == CW'(1))) begin
                        state_q <= StFetch;
                    end
                end
                if (push) begin
                    buf_inst_q[wr_ptr_q] <= imem_resp_data;
                    buf_pc_q[wr_ptr_q]   <= resp_pc_q;
                    wr_ptr_q             <= wr_ptr_q + PW'(1);
                    resp_pc_q            <= resp_pc_q + 32'd4;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                count_q <= count_nx;
            end
        end
    end

`ifndef SYNTHESIS
    fifo_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && !pop && (count_q == DEPTH_C)));
    resp_has_request: assert property (@(posedge clock) disable iff (!reset_n)
        !(imem_resp_valid && (outstanding_q == '0)));
`endif

endmodule
